// File: rtl/multiword_add_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-word chunked adder.
// Latency: none (declarations only). Backpressure: not applicable.
// Holds the sequencer state encoding, counter sizing and chunk slicing math.
package multiword_add_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_W = 8;
    localparam int DEF_K = 4;

    // Chunk counter needs at least one bit even when K=1.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Low bit position of chunk idx in a word built from w-bit chunks.
    function automatic int chunk_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder, the shared chunk datapath.
// Latency: purely combinational.
// Backpressure: none; outputs track inputs continuously.
module ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] iA,
    input  logic [N-1:0] iB,
    input  logic         iC,
    output logic [N-1:0] oS,
    output logic         oC
);

    always_comb begin
        logic carry;
        oS    = '0;
        carry = iC;
        for (int i = 0; i < N; i++) begin
            oS[i] = iA[i] ^ iB[i] ^ carry;
            carry = (iA[i] & iB[i]) | (carry & (iA[i] ^ iB[i]));
        end
        oC = carry;
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Adds two W*K-bit operands through one W-bit ripple_adder, LS chunk first (MULTIWORD_ADD_CTRL_SUB_EN adds iSub).
// Latency: start accepted at edge t, oDone pulses in the cycle after edge t+K; one op per K+1 cycles.
// Backpressure: oReady low while busy; iStart is ignored (not queued) until oReady returns.
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
) (
    input  logic           iClk,
    input  logic           iRst_n,
    input  logic           iStart,
    input  logic [W*K-1:0] iA,
    input  logic [W*K-1:0] iB,
    input  logic           iC,
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    input  logic           iSub,
`endif
    output logic           oReady,
    output logic           oDone,
    output logic [W*K-1:0] oS,
    output logic           oC
);

    localparam int            TW   = W * K;
    localparam int            CW   = cnt_width(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry_q;
    logic [TW-1:0] a_q;
    logic [TW-1:0] b_q;
    logic [TW-1:0] s_q;
    logic          c_q;
    logic          done_q;
    logic          ready_q;

    logic [TW-1:0] b_in;
    logic          c_in;
    logic [W-1:0]  a_chunk;
    logic [W-1:0]  b_chunk;
    logic [W-1:0]  sum;
    logic          carry_out;

    // Subtraction is A + ~B + 1, so only the latched B and the initial carry change.
    always_comb begin
        b_in = iB;
        c_in = iC;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        if (iSub) begin
            b_in = ~iB;
            c_in = 1'b1;
        end
`endif
    end

    assign a_chunk = a_q[chunk_lo(int'(cnt), W) +: W];
    assign b_chunk = b_q[chunk_lo(int'(cnt), W) +: W];

    ripple_adder #(
        .N (W)
    ) u_adder (
        .iA (a_chunk),
        .iB (b_chunk),
        .iC (carry_q),
        .oS (sum),
        .oC (carry_out)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        a_q     <= iA;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Result is built in place; upper chunks keep old data until reached.
                    s_q[chunk_lo(int'(cnt), W) +: W] <= sum;
                    carry_q <= carry_out;
                    if (cnt == LAST) begin
                        c_q     <= carry_out;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign oReady = ready_q;
    assign oDone  = done_q;
    assign oS     = s_q;
    assign oC     = c_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl: W=8/K=4 instance plus a W=8/K=1 instance.
module tb_multiword_add_ctrl;

    localparam int K = 4;

    logic        iClk;
    logic        rst_n;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    logic        sub;
`endif
    logic        ready;
    logic        done;
    logic [31:0] s;
    logic        co;

    logic        start1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        c1;
    logic        ready1;
    logic        done1;
    logic [7:0]  s1;
    logic        co1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        logic        sub;
`endif
        logic [31:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    multiword_add_ctrl #(.W(8), .K(4)) dut (
        .iClk   (iClk),
        .iRst_n (rst_n),
        .iStart (start),
        .iA     (a),
        .iB     (b),
        .iC     (c),
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        .iSub   (sub),
`endif
        .oReady (ready),
        .oDone  (done),
        .oS     (s),
        .oC     (co)
    );

    multiword_add_ctrl #(.W(8), .K(1)) dut_k1 (
        .iClk   (iClk),
        .iRst_n (rst_n),
        .iStart (start1),
        .iA     (a1),
        .iB     (b1),
        .iC     (c1),
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        .iSub   (1'b0),
`endif
        .oReady (ready1),
        .oDone  (done1),
        .oS     (s1),
        .oC     (co1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                           input logic [31:0] es, input logic ec);
        vec_t v;
        v.a = va; v.b = vb; v.c = vc; v.es = es; v.ec = ec;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        v.sub = 1'b0;
`endif
        vecs.push_back(v);
    endtask

`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    task automatic add_sub_vec(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                               input logic [31:0] es, input logic ec);
        vec_t v;
        v.a = va; v.b = vb; v.c = vc; v.es = es; v.ec = ec; v.sub = 1'b1;
        vecs.push_back(v);
    endtask
`endif

    // Called just after a negedge; returns one negedge after the accepting edge.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        start = 1'b1;
        a     = ta;
        b     = tb;
        c     = tc;
        @(negedge iClk);
        start = 1'b0;
    endtask

    // lat counts negedges from the first one after acceptance; K+1 is expected.
    task automatic wait_done(output int lat, output logic rdy_bad);
        lat     = 1;
        rdy_bad = 1'b0;
        while (!done && lat < 20) begin
            if (ready) rdy_bad = 1'b1;
            @(negedge iClk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        rbad;
        int          pulses;
        logic [31:0] got_s;
        logic        got_c;
        logic [7:0]  k1_a [2];
        logic [7:0]  k1_b [2];
        logic        k1_c [2];
        logic [7:0]  k1_s [2];
        logic        k1_co[2];

        rst_n  = 1'b0;
        start  = 1'b0; a  = '0; b  = '0; c  = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        sub = 1'b0;
`endif

        add_vec(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
        add_vec(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        add_vec(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0);
        add_vec(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
        add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        add_vec(32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0);
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        add_sub_vec(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0);
        add_sub_vec(32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1);
`endif

        k1_a[0] = 8'hFF; k1_b[0] = 8'h01; k1_c[0] = 1'b0; k1_s[0] = 8'h00; k1_co[0] = 1'b1;
        k1_a[1] = 8'h7F; k1_b[1] = 8'h01; k1_c[1] = 1'b1; k1_s[1] = 8'h81; k1_co[1] = 1'b0;

        #12;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sum",   64'(s),     64'd0);
        check("rst_cout",  64'(co),    64'd0);
        check("rst_k1_ready", 64'(ready1), 64'd1);
        @(negedge iClk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
            sub = vecs[i].sub;
`endif
            start_op(vecs[i].a, vecs[i].b, vecs[i].c);
            wait_done(lat, rbad);
            check($sformatf("v%0d_latency", i),   64'(lat),  64'(K + 1));
            check($sformatf("v%0d_ready_busy", i), 64'(rbad), 64'd0);
            check($sformatf("v%0d_sum", i),       64'(s),    64'(vecs[i].es));
            check($sformatf("v%0d_cout", i),      64'(co),   64'(vecs[i].ec));
            check($sformatf("v%0d_ready_done", i), 64'(ready), 64'd1);
            @(negedge iClk);
            check($sformatf("v%0d_pulse_end", i), 64'(done), 64'd0);
            check($sformatf("v%0d_sum_hold", i),  64'(s),    64'(vecs[i].es));
        end
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
        sub = 1'b0;
`endif

        // A second start during RUN must be dropped without disturbing the first.
        start_op(32'h12345678, 32'h11111111, 1'b0);
        @(negedge iClk);
        start = 1'b1; a = 32'hDEADBEEF; b = 32'hCAFEF00D; c = 1'b1;
        @(negedge iClk);
        start = 1'b0;
        pulses = 0; got_s = '0; got_c = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (done) begin
                pulses++;
                got_s = s;
                got_c = co;
            end
            @(negedge iClk);
        end
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_sum",    64'(got_s),  64'h23456789);
        check("busy_start_cout",   64'(got_c),  64'd0);

        // Start issued in the oDone cycle is accepted immediately.
        start_op(32'h00000010, 32'h00000020, 1'b0);
        wait_done(lat, rbad);
        check("b2b_first_lat", 64'(lat), 64'(K + 1));
        check("b2b_first_sum", 64'(s),   64'h00000030);
        start_op(32'h10000000, 32'h20000000, 1'b0);
        wait_done(lat, rbad);
        check("b2b_second_lat",  64'(lat),  64'(K + 1));
        check("b2b_second_busy", 64'(rbad), 64'd0);
        check("b2b_second_sum",  64'(s),    64'h30000000);

        // Mid-run reset: chunk 0 is already rewritten, upper chunks still old.
        @(negedge iClk);
        start_op(32'h01010101, 32'h01010101, 1'b0);
        @(negedge iClk);
        check("partial_sum", 64'(s), 64'h30000002);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum",   64'(s),     64'd0);
        check("arst_cout",  64'(co),    64'd0);
        check("arst_done",  64'(done),  64'd0);
        check("arst_ready", 64'(ready), 64'd1);
        @(negedge iClk);
        rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            if (done) pulses++;
            @(negedge iClk);
        end
        check("arst_no_done", 64'(pulses), 64'd0);
        start_op(32'd3, 32'd4, 1'b0);
        wait_done(lat, rbad);
        check("post_rst_lat",  64'(lat), 64'(K + 1));
        check("post_rst_sum",  64'(s),   64'd7);
        check("post_rst_cout", 64'(co),  64'd0);
        @(negedge iClk);

        for (int i = 0; i < 2; i++) begin
            start1 = 1'b1; a1 = k1_a[i]; b1 = k1_b[i]; c1 = k1_c[i];
            @(negedge iClk);
            start1 = 1'b0;
            check($sformatf("k1_%0d_ready_run", i), 64'(ready1), 64'd0);
            check($sformatf("k1_%0d_done_run", i),  64'(done1),  64'd0);
            @(negedge iClk);
            check($sformatf("k1_%0d_done", i),  64'(done1),  64'd1);
            check($sformatf("k1_%0d_sum", i),   64'(s1),     64'(k1_s[i]));
            check($sformatf("k1_%0d_cout", i),  64'(co1),    64'(k1_co[i]));
            check($sformatf("k1_%0d_ready", i), 64'(ready1), 64'd1);
            @(negedge iClk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
